instr_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the decode block. It owns the program counter and issues single-outstanding word requests to instruction memory over a req/ack handshake. Returned words go into a small prefetch FIFO, which presents instructions with valid/ready to decode and splits out the opcode, func3 and func7 fields that decode consumes. It supports a redirect (branch/jump) that flushes buffered and in-flight instructions.

---
 rtl/instr_fetch.sv | 212 +++++++++++++++++++++
 tb/tb_instr_fetch.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues single-outstanding imem word requests, buffers returns for decode.
// Latency: first out_valid two cycles after reset release or redirect with zero-wait memory.
// Backpressure: out_ready low fills the prefetch FIFO; requests stop while no slot is free.
// Optional build macro FETCH_ALIGN_CHECK_EN adds fetch_fault for misaligned redirect targets.

// Small prefetch FIFO with synchronous flush; head is read straight from storage.
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  assign head_data = mem[rd_ptr];

  // Pointer and occupancy tracking; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Entry storage; cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        fetch_fault,
`endif
  output logic [6:0]  func7
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic          fault_q;
  logic          misaligned;
  logic [31:0]   target_pc;
  logic          push;
  logic          pop;
  logic          busy_unacked;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_after_pop;
  logic [CW-1:0] cnt_next;
  logic [63:0]   head;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned  = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = fault_q;
`else
  // Low address bits are dropped: every redirect lands on a word boundary.
  logic unused_lsbs;
  assign unused_lsbs = ^redirect_pc[1:0];
  assign misaligned  = 1'b0;
`endif

  assign target_pc = {redirect_pc[31:2], 2'b00};

  // A request (or a flush wait) that has not seen its ack yet will still be acked later.
  assign busy_unacked = ((state == REQ) || (state == FLUSH)) && !imem_ack;

  assign pop  = out_valid && out_ready;
  assign push = (state == REQ) && imem_ack && !redirect;

  // Occupancy as seen after this edge; a same-cycle pop frees a slot for the next request.
  assign cnt_after_pop = count - {{AW{1'b0}}, pop};
  assign cnt_next      = cnt_after_pop + {{AW{1'b0}}, push};

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_pc    = head[63:32];
  assign out_instr = head[31:0];
  assign opcode    = out_instr[6:0];
  assign func3     = out_instr[14:12];
  assign func7     = out_instr[31:25];

  if_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data ({pc, imem_rdata}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  // Fetch control: redirect first, then the IDLE/REQ/FLUSH request sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      imem_req <= 1'b0;
      fault_q  <= 1'b0;
    end else if (redirect) begin
      if (misaligned) begin
        // No fetch from a bad target; an outstanding ack still has to be absorbed.
        fault_q  <= 1'b1;
        imem_req <= 1'b0;
        state    <= busy_unacked ? FLUSH : IDLE;
      end else begin
        fault_q <= 1'b0;
        pc      <= target_pc;
        if (busy_unacked) begin
          state    <= FLUSH;
          imem_req <= 1'b0;
        end else begin
          // Either nothing pending or the pending ack lands now and is dropped.
          state    <= REQ;
          imem_req <= 1'b1;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (!fault_q && (cnt_after_pop < DEPTH_C)) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack) begin
            pc <= pc + 32'd4;
            if (cnt_next < DEPTH_C) begin
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (imem_ack) begin
            if (fault_q) begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end else begin
              state    <= REQ;
              imem_req <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed phases with a queue-based scoreboard on the decode-side handshake.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .opcode      (opcode),
    .func3       (func3),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_fault (fetch_fault),
`endif
    .func7       (func7)
  );

  // Memory model: one ack per request after lat wait cycles, ack owed even once req drops.
  int   lat = 0;
  logic sub_mode = 1'b0;
  logic pending = 1'b0;
  int   waitc = 0;

  assign imem_ack   = !rst && (imem_req || pending) && (waitc >= lat);
  assign imem_rdata = (sub_mode && imem_addr == 32'h0) ? 32'h4000_00B3 : (imem_addr ^ 32'hA5A5_0000);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      waitc   <= 0;
    end else if (imem_ack) begin
      pending <= 1'b0;
      waitc   <= 0;
    end else if (imem_req || pending) begin
      pending <= 1'b1;
      waitc   <= waitc + 1;
    end
  end

  int          cyc = 0;
  int          ack_cnt = 0;
  logic [31:0] ack_addrs[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (imem_ack) begin
      ack_cnt <= ack_cnt + 1;
      ack_addrs.push_back(imem_addr);
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          hs_cyc[$];
  logic [31:0] hs_pc[$];
  int          errors = 0;
  int          checks = 0;
  int          rel = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk_hs(input string name, input int idx, input logic [31:0] req);
    if (hs_pc.size() > idx) begin
      chk(name, hs_pc[idx], req);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: no transfer seen, expected pc %h", name, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = start + 32'(4 * i);
      e.instr = e.pc ^ 32'hA5A5_0000;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect = 1'b0;
    out_ready = rdy;
    tick(2);
    exp_q.delete();
    rst = 1'b0;
    rel = cyc;
  endtask

  // Scoreboard monitor: every accepted head is compared against the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !redirect && out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      hs_pc.push_back(out_pc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h with nothing expected", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_instr", out_instr, e.instr);
        chk("sb_opcode", 32'(opcode), 32'(e.instr[6:0]));
        chk("sb_func3", 32'(func3), 32'(e.instr[14:12]));
        chk("sb_func7", 32'(func7), 32'(e.instr[31:25]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int ab;
    logic saw_req;

    // Reset values.
    tick(2);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_fault", 32'(fetch_fault), 32'd0);
`endif

    // Zero-wait streaming from reset: pcs 0,4,8,12 on consecutive cycles.
    do_reset(1'b1);
    push_stream(32'h0, 20);
    tick(1);
    chk("a_valid_c1", 32'(out_valid), 32'd0);
    chk("a_req_c1", 32'(imem_req), 32'd1);
    tick(8);
    for (int i = 0; i < 4; i++) begin
      if (hs_cyc.size() > i) chk("a_hs_cycle", 32'(hs_cyc[i]), 32'(rel + 2 + i));
      else chk_hs("a_hs_missing", i, 32'(4 * i));
    end

    // Reset applied asynchronously mid-stream.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);

    // Backpressure: exactly two acks, then requests stop; resume pops 0,4 and fetches 8.
    do_reset(1'b0);
    base = ack_cnt;
    ab = ack_addrs.size();
    tick(10);
    chk("b_ack_count", 32'(ack_cnt - base), 32'd2);
    chk("b_req_idle", 32'(imem_req), 32'd0);
    chk("b_valid_full", 32'(out_valid), 32'd1);
    push_stream(32'h0, 20);
    out_ready = 1'b1;
    tick(6);
    if (ack_addrs.size() > ab + 2) chk("b_resume_addr", ack_addrs[ab + 2], 32'h8);
    else chk("b_resume_missing", 32'(ack_addrs.size()), 32'(ab + 3));

    // Field split for SUB x1,x0,x0 at pc 0.
    sub_mode = 1'b1;
    do_reset(1'b0);
    tick(3);
    chk("c_valid", 32'(out_valid), 32'd1);
    chk("c_pc", out_pc, 32'h0);
    chk("c_instr", out_instr, 32'h4000_00B3);
    chk("c_opcode", 32'(opcode), 32'(7'b0110011));
    chk("c_func3", 32'(func3), 32'd0);
    chk("c_func7", 32'(func7), 32'h20);
    sub_mode = 1'b0;

    // Redirect while the request to 8 waits on a slow ack: its data must be discarded.
    do_reset(1'b0);
    tick(4);
    push_stream(32'h0, 2);
    lat = 3;
    out_ready = 1'b1;
    n = 0;
    while (!imem_req && n < 10) begin
      tick(1);
      n++;
    end
    chk("d_req_timeout", 32'(n < 10), 32'd1);
    chk("d_req_addr", imem_addr, 32'h8);
    tick(1);
    chk("d_ack_pending", 32'(imem_ack), 32'd0);
    chk("d_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    push_stream(32'h100, 10);
    base = hs_pc.size();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick(1);
    redirect = 1'b0;
    n = 0;
    saw_req = 1'b0;
    while (!imem_ack && n < 10) begin
      if (imem_req) saw_req = 1'b1;
      tick(1);
      n++;
    end
    chk("d_flush_timeout", 32'(n < 10), 32'd1);
    chk("d_flush_wait", 32'(n >= 1), 32'd1);
    chk("d_no_req_flush", 32'(saw_req), 32'd0);
    chk("d_req_ack_cycle", 32'(imem_req), 32'd0);
    tick(20);
    chk_hs("d_first_after", base, 32'h100);
    chk_hs("d_second_after", base + 1, 32'h104);
    lat = 0;

    // Redirect with a full FIFO, then redirect coinciding with an ack.
    do_reset(1'b0);
    tick(4);
    chk("e_full_idle", 32'(imem_req), 32'd0);
    push_stream(32'h300, 20);
    redirect = 1'b1;
    redirect_pc = 32'h300;
    tick(1);
    redirect = 1'b0;
    chk("e_valid_cleared", 32'(out_valid), 32'd0);
    chk("e_req_addr", imem_addr, 32'h300);
    tick(1);
    chk("e_valid_new", 32'(out_valid), 32'd1);
    chk("e_pc_new", out_pc, 32'h300);
    base = hs_pc.size();
    out_ready = 1'b1;
    tick(5);
    chk_hs("e_first_pop", base, 32'h300);
    chk("e_ack_same", 32'(imem_ack), 32'd1);
    exp_q.delete();
    push_stream(32'h400, 20);
    base = hs_pc.size();
    redirect = 1'b1;
    redirect_pc = 32'h400;
    tick(1);
    redirect = 1'b0;
    chk("e_valid_cleared2", 32'(out_valid), 32'd0);
    tick(5);
    chk_hs("e_first_after_ack", base, 32'h400);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect faults and stalls until an aligned redirect arrives.
    exp_q.delete();
    redirect = 1'b1;
    redirect_pc = 32'h102;
    tick(1);
    redirect = 1'b0;
    chk("f_fault_set", 32'(fetch_fault), 32'd1);
    saw_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req || out_valid) saw_req = 1'b1;
      tick(1);
    end
    chk("f_stalled", 32'(saw_req), 32'd0);
    chk("f_fault_held", 32'(fetch_fault), 32'd1);
    push_stream(32'h200, 20);
    base = hs_pc.size();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick(1);
    redirect = 1'b0;
    chk("f_fault_clear", 32'(fetch_fault), 32'd0);
    tick(5);
    chk_hs("f_resume_pc", base, 32'h200);
`else
    // Misaligned target low bits are ignored.
    exp_q.delete();
    push_stream(32'h100, 20);
    base = hs_pc.size();
    redirect = 1'b1;
    redirect_pc = 32'h102;
    tick(1);
    redirect = 1'b0;
    tick(5);
    chk_hs("f_masked_pc", base, 32'h100);
`endif

    out_ready = 1'b0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
